// File: rtl/updown_dir_ctrl_if.sv
// Bundles the pushbutton inputs, the count feedback and the counter control outputs of updown_dir_ctrl.
// There is no latency here: this file only declares wires and modports.
// There is no backpressure: all signals are level signals with no handshake.
// The optional dir_change signal exists only when DIR_CHANGE_PULSE_EN is defined.
interface updown_dir_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             btn_up;
    logic             btn_down;
    logic             btn_clr;
    logic             btn_mode;
    logic [CNT_W-1:0] count_in;
    logic             dir_up;
    logic             clear;
    logic             bounce_mode;
`ifdef DIR_CHANGE_PULSE_EN
    logic             dir_change;
`endif

    // Button and feedback source side (board/testbench plus the counter).
    modport master (
        output btn_up, btn_down, btn_clr, btn_mode, count_in,
`ifdef DIR_CHANGE_PULSE_EN
        input  dir_change,
`endif
        input  dir_up, clear, bounce_mode
    );

    // Direction controller side.
    modport slave (
        input  btn_up, btn_down, btn_clr, btn_mode, count_in,
`ifdef DIR_CHANGE_PULSE_EN
        output dir_change,
`endif
        output dir_up, clear, bounce_mode
    );
endinterface

// File: rtl/updown_dir_ctrl.sv
// Purpose: debounce four pushbuttons and drive dir_up/clear of an up/down counter, with optional ping-pong bounce.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a clean raw edge to the registered output change.
// Backpressure: none; the buttons are level inputs and the outputs are free-running registers.
// Optional feature macro DIR_CHANGE_PULSE_EN adds a registered one-cycle dir_change pulse.
module updown_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 3,
    parameter int CLEAR_HOLD      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    updown_dir_ctrl_if.slave  io
);
    localparam int NB     = 4;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CLEAR_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    // Reverse one step before the terminal values because dir_up reaches the counter one edge late.
    localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'((1 << CNT_W) - 2);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // Button lanes: 0 up, 1 down, 2 clear, 3 mode.
    logic [NB-1:0]   btn_raw;
    logic [NB-1:0]   sync_a;
    logic [NB-1:0]   sync_b;
    logic [NB-1:0]   deb_lvl;
    logic [DB_W-1:0] deb_cnt [NB];
    logic [NB-1:0]   press;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              dir_up_q;
    logic              clear_q;
    logic              bounce_q;

    assign btn_raw = {io.btn_mode, io.btn_clr, io.btn_down, io.btn_up};

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: count consecutive disagreeing samples and adopt the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= '0;
            for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_LAST) begin
                    deb_lvl[i] <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Press strobe is high in the cycle whose closing edge raises the debounced level.
    always_comb begin
        press = '0;
        for (int i = 0; i < NB; i++)
            press[i] = sync_b[i] && !deb_lvl[i] && (deb_cnt[i] == DB_LAST);
    end

    logic press_up, press_down, press_clr, press_mode;
    logic manual_up, manual_down;
    logic exit_clr, to_clr, to_up, to_down;

    assign press_up    = press[0];
    assign press_down  = press[1];
    assign press_clr   = press[2];
    assign press_mode  = press[3];
    // Simultaneous up and down presses cancel each other.
    assign manual_up   = press_up && !press_down;
    assign manual_down = press_down && !press_up;

    assign exit_clr = (state == ST_CLR) && !press_clr && (hold_cnt == HOLD_ONE);
    assign to_clr   = (state != ST_CLR) && press_clr;
    assign to_down  = (state == ST_UP) && !press_clr &&
                      (manual_down || (bounce_q && io.count_in == CNT_TOP));
    assign to_up    = (state == ST_DOWN) && !press_clr &&
                      (manual_up || (bounce_q && io.count_in == CNT_ONE));

    // Direction FSM with registered outputs; clear has priority over manual presses, which beat bounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLR;
            hold_cnt <= HOLD_INIT;
            clear_q  <= 1'b1;
            dir_up_q <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            bounce_q <= bounce_q ^ press_mode;
            if (to_clr) begin
                state    <= ST_CLR;
                hold_cnt <= HOLD_INIT;
                clear_q  <= 1'b1;
                dir_up_q <= 1'b0;
            end else begin
                case (state)
                    ST_CLR: begin
                        if (press_clr) begin
                            hold_cnt <= HOLD_INIT;
                        end else if (exit_clr) begin
                            state    <= ST_UP;
                            clear_q  <= 1'b0;
                            dir_up_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_ONE;
                        end
                    end
                    ST_UP: begin
                        if (to_down) begin
                            state    <= ST_DOWN;
                            dir_up_q <= 1'b0;
                        end
                    end
                    ST_DOWN: begin
                        if (to_up) begin
                            state    <= ST_UP;
                            dir_up_q <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_CLR;
                        hold_cnt <= HOLD_INIT;
                        clear_q  <= 1'b1;
                        dir_up_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.dir_up      = dir_up_q;
    assign io.clear       = clear_q;
    assign io.bounce_mode = bounce_q;

`ifdef DIR_CHANGE_PULSE_EN
    logic dir_change_q;

    // Flag every edge on which dir_up toggles; DOWN->CLR keeps dir_up at 0 and is excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dir_change_q <= 1'b0;
        else        dir_change_q <= exit_clr || to_down || to_up || (to_clr && state == ST_UP);
    end

    assign io.dir_change = dir_change_q;
`endif

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl with a behavioural up/down counter closing the count loop.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there as well.
// Uses DEBOUNCE_CYCLES=4, CLEAR_HOLD=2 and CNT_W=3.
module tb_updown_dir_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] count = 3'd0;

    int n_tests = 0;
    int n_fail  = 0;

    updown_dir_ctrl_if #(.CNT_W(3)) io ();

    updown_dir_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .CLEAR_HOLD      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Model of the downstream counter: it counts every cycle and wraps when free-running.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         count <= 3'd0;
        else if (io.clear)  count <= 3'd0;
        else if (io.dir_up) count <= count + 3'd1;
        else                count <= count - 3'd1;
    end
    assign io.count_in = count;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef DIR_CHANGE_PULSE_EN
    int   dc_err    = 0;
    int   dc_pulses = 0;
    logic prev_dir  = 1'b0;
    bit   prev_ok   = 1'b0;

    // dir_change must be high exactly in the cycles where dir_up differs from the previous cycle.
    always @(negedge clk) begin
        if (rst_n && prev_ok) begin
            if (io.dir_change !== (io.dir_up != prev_dir)) dc_err++;
            if (io.dir_change) dc_pulses++;
        end
        prev_dir = io.dir_up;
        prev_ok  = rst_n;
    end
`endif

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int fall;
        int prev;
        int wraps;
        int bad_steps;
        int tops;
        int bots;

        io.btn_up   = 1'b0;
        io.btn_down = 1'b0;
        io.btn_clr  = 1'b0;
        io.btn_mode = 1'b0;

        // Reset values while rst_n is held low.
        tick(2);
        chk("rst_clear", int'(io.clear), 1);
        chk("rst_dir_up", int'(io.dir_up), 0);
        chk("rst_bounce", int'(io.bounce_mode), 0);

        // Release: clear stays high for two cycles, then UP.
        rst_n = 1'b1;
        tick(1);
        chk("clr_hold1_clear", int'(io.clear), 1);
        chk("clr_hold1_dir", int'(io.dir_up), 0);
        tick(1);
        chk("clr_exit_clear", int'(io.clear), 0);
        chk("clr_exit_dir", int'(io.dir_up), 1);
        chk("clr_exit_bounce", int'(io.bounce_mode), 0);

        // Held down button: dir_up falls 6 edges after the raw edge, release changes nothing.
        tick(5);
        io.btn_down = 1'b1;
        fall = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (fall == 0 && io.dir_up == 1'b0) fall = k;
            if (k == 10) io.btn_down = 1'b0;
        end
        chk("down_latency", fall, 6);
        tick(12);
        chk("down_release", int'(io.dir_up), 0);

        // Three-cycle glitch on up is filtered out.
        io.btn_up = 1'b1;
        tick(3);
        io.btn_up = 1'b0;
        tick(10);
        chk("glitch_up", int'(io.dir_up), 0);

        // Up and down together cancel.
        io.btn_up   = 1'b1;
        io.btn_down = 1'b1;
        tick(10);
        io.btn_up   = 1'b0;
        io.btn_down = 1'b0;
        tick(10);
        chk("both_pressed", int'(io.dir_up), 0);

        // A lone up press turns the direction back up.
        io.btn_up = 1'b1;
        tick(8);
        io.btn_up = 1'b0;
        tick(8);
        chk("manual_up", int'(io.dir_up), 1);

        // Enable bounce and watch three full 0..7..0 periods.
        io.btn_mode = 1'b1;
        tick(8);
        io.btn_mode = 1'b0;
        tick(1);
        chk("bounce_on", int'(io.bounce_mode), 1);
        tick(20);
        prev = int'(count);
        wraps = 0; bad_steps = 0; tops = 0; bots = 0;
        for (int k = 0; k < 42; k++) begin
            tick(1);
            if ((prev == 7 && count == 3'd0) || (prev == 0 && count == 3'd7)) wraps++;
            else if (!(int'(count) == prev + 1 || int'(count) == prev - 1)) bad_steps++;
            if (count == 3'd7) tops++;
            if (count == 3'd0) bots++;
            prev = int'(count);
        end
        chk("bounce_wraps", wraps, 0);
        chk("bounce_steps", bad_steps, 0);
        chk("bounce_tops", tops, 3);
        chk("bounce_bottoms", bots, 3);

        // Turn bounce off again and park in DOWN.
        io.btn_mode = 1'b1;
        tick(8);
        io.btn_mode = 1'b0;
        tick(8);
        chk("bounce_off", int'(io.bounce_mode), 0);
        io.btn_down = 1'b1;
        tick(8);
        io.btn_down = 1'b0;
        tick(8);
        chk("park_down", int'(io.dir_up), 0);

        // Clear and mode together from DOWN.
        io.btn_clr  = 1'b1;
        io.btn_mode = 1'b1;
        tick(5);
        chk("clrmode_pre_clear", int'(io.clear), 0);
        tick(1);
        chk("clrmode_clear0", int'(io.clear), 1);
        chk("clrmode_dir0", int'(io.dir_up), 0);
        chk("clrmode_bounce", int'(io.bounce_mode), 1);
        tick(1);
        chk("clrmode_clear1", int'(io.clear), 1);
        tick(1);
        chk("clrmode_clear2", int'(io.clear), 0);
        chk("clrmode_dir2", int'(io.dir_up), 1);
        io.btn_clr  = 1'b0;
        io.btn_mode = 1'b0;
        tick(10);

        // Asynchronous reset in the middle of a debounce.
        io.btn_down = 1'b1;
        tick(3);
        io.btn_down = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_clear", int'(io.clear), 1);
        chk("midrst_dir", int'(io.dir_up), 0);
        chk("midrst_bounce", int'(io.bounce_mode), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("midrst_exit_dir", int'(io.dir_up), 1);
        chk("midrst_exit_clear", int'(io.clear), 0);
        tick(10);
        chk("midrst_settled", int'(io.dir_up), 1);

`ifdef DIR_CHANGE_PULSE_EN
        chk("dir_change_err", dc_err, 0);
        chk("dir_change_seen", int'(dc_pulses >= 8), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/updown_dir_ctrl.md
Name: updown_dir_ctrl

Overview:
- Control stage directly upstream of updown_counter; generates its dir_up and clear inputs from raw pushbuttons.
- Synchronises and debounces four buttons (up, down, clear, mode) and runs a direction FSM.
- Optional "bounce" mode reads the counter's count back and reverses direction just before the terminal values, giving a 0..MAX..0 ping-pong with no wrap-around.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronised samples needed before a button's debounced level changes.
- CNT_W, 3: width of count_in; MAX = 2^CNT_W - 1.
- CLEAR_HOLD, 2: number of clk cycles clear is held high per clear request.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_up  in  1  raw, asynchronous, active-high; request count up.
- btn_down  in  1  raw, asynchronous, active-high; request count down.
- btn_clr  in  1  raw, asynchronous, active-high; request counter clear.
- btn_mode  in  1  raw, asynchronous, active-high; toggle bounce mode.
- count_in  in  CNT_W  registered count fed back from updown_counter.
- dir_up  out  1  registered; to counter dir_up; 1 = up.
- clear  out  1  registered; to counter clear.
- bounce_mode  out  1  registered; 1 = auto-reverse enabled.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=CLR, clear=1, dir_up=0, bounce_mode=0.
  - hold counter = CLEAR_HOLD; all synchronisers, debounced levels and debounce counters = 0.
- Input conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - The counter increments while the synchronised value differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A press is a 1-cycle pulse on a 0->1 transition of the debounced level.
  - Latency from a clean raw edge to the press pulse is 2 + DEBOUNCE_CYCLES cycles.
- State CLR:
  - clear=1, dir_up=0.
  - The hold counter decrements each cycle. When it reaches 1, the next state is UP, with clear=0 and dir_up=1 registered on the same edge.
  - A press_clr while in CLR reloads the hold counter to CLEAR_HOLD.
  - press_up and press_down are ignored in CLR.
- State UP:
  - dir_up=1, clear=0.
  - press_clr -> CLR (clear=1 and the hold counter loaded on the next edge).
  - press_down alone -> DOWN.
  - If bounce_mode=1 and count_in==MAX-1 -> DOWN.
- State DOWN:
  - dir_up=0, clear=0.
  - press_clr -> CLR.
  - press_up alone -> UP.
  - If bounce_mode=1 and count_in==1 -> UP.
- Anticipation rule: dir_up is registered, so the counter sees the new direction one edge late. Reversing at MAX-1 (or 1) makes the counter hit MAX (or 0) exactly once.
  - Required up sequence: ..., MAX-2, MAX-1, MAX, MAX-1, ...
  - Required down sequence: ..., 2, 1, 0, 1, ...
- Priority in one cycle: press_clr > manual direction press > bounce reversal.
  - press_up and press_down in the same cycle: both ignored; direction unchanged.
  - A manual press toward the current direction: no effect.
- Mode:
  - press_mode toggles bounce_mode in any state, including CLR.
  - A mode press coincident with press_clr applies both.
  - Enabling bounce while count_in is already at MAX with dir_up=1 (or 0 with dir_up=0): one wrap occurs, then normal bounce resumes. This is accepted behaviour.
- Button held down: generates exactly one press; release generates none.
- A glitch shorter than DEBOUNCE_CYCLES: no press.
- Reset mid-operation: immediate return to the reset values, regardless of state or debounce progress.

Optional Feature:
- Macro: DIR_CHANGE_PULSE_EN.
- Defined:
  - Adds output port dir_change (1 bit, registered, reset 0).
  - dir_change is high for exactly one cycle in the cycle after any edge where dir_up toggles, including the CLR->UP exit.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and CLEAR_HOLD=2 throughout.
- Reset, release rst_n, no buttons -> clear=1 for 2 cycles after reset release, then clear=0 and dir_up=1; bounce_mode=0.
- From UP, btn_down high for 10 cycles -> dir_up falls exactly 6 cycles after the raw edge; btn_down released -> no further change.
- btn_up glitch of 3 cycles -> no change; btn_up and btn_down pressed in the same cycle -> direction unchanged.
- Bounce mode with the counter model attached -> count sequence 0,1,...,7,6,...,0,1 with no 7->0 or 0->7 transition over 3 full periods.
- press_clr while in DOWN and press_mode coincident -> clear=1 for 2 cycles, then UP with bounce_mode toggled; rst_n pulse mid-debounce -> all outputs at reset values immediately.
- With DIR_CHANGE_PULSE_EN defined -> dir_change is a 1-cycle pulse after each dir_up toggle, and 0 otherwise.
